clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 115 +++++++++++
 tb/tb_clk_div_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with clean start/stop at period boundaries and a
// one-entry pending register for glitch-free divide-ratio changes.
module clk_div_ctrl #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] cur_div
);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             cfg_err_q, cfg_err_d;

  logic             boundary;
  logic             xfer;
  logic [WIDTH-1:0] cnt_nxt;

  // cur_div is always >= 2, so cur_div-1 and cnt+1 never wrap.
  assign boundary = (state_q != STOP) && (cnt_q == cur_div_q - WIDTH'(1));
  assign cnt_nxt  = cnt_q + WIDTH'(1);
  assign xfer     = cfg_valid && !pend_valid_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    cur_div_d    = cur_div_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    cfg_err_d    = 1'b0;

    if (state_q == STOP) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      if (pend_valid_q) begin
        cur_div_d    = pend_div_q;
        pend_valid_d = 1'b0;
      end
      if (en) begin
        state_d   = RUN;
        clk_out_d = 1'b1;
      end
    end else if (boundary) begin
      if (pend_valid_q) begin
        cur_div_d    = pend_div_q;
        pend_valid_d = 1'b0;
      end
      cnt_d     = '0;
      state_d   = en ? RUN : STOP;
      clk_out_d = en;
    end else begin
      cnt_d     = cnt_nxt;
      clk_out_d = (cnt_nxt < (cur_div_q >> 1));
      state_d   = en ? RUN : DRAIN;
    end

    // Pending slot is empty whenever a transfer happens, so no clash with apply above.
    if (xfer) begin
      if (cfg_div >= WIDTH'(2)) begin
        pend_valid_d = 1'b1;
        pend_div_d   = cfg_div;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q      <= STOP;
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      cur_div_q    <= WIDTH'(DEFAULT_DIV);
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      cur_div_q    <= cur_div_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_ready = !pend_valid_q;
  assign cfg_err   = cfg_err_q;
  assign clk_out   = clk_out_q;
  assign tick      = boundary;
  assign running   = (state_q != STOP);
  assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: start/stop, drain, ratio changes, illegal ratio, reset.
module tb_clk_div_ctrl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic        cfg_err;
  logic        clk_out;
  logic        tick;
  logic        running;
  logic [15:0] cur_div;

  int total = 0;
  int bad   = 0;

  clk_div_ctrl #(.WIDTH(16), .DEFAULT_DIV(4)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .cur_div   (cur_div)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks n consecutive cycles starting now; bit i of each pattern is cycle i.
  task automatic run_pat(input string tag, input int n, input logic [7:0] cp, input logic [7:0] tp);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_clk"}, {31'd0, clk_out}, {31'd0, cp[i]});
      chk({tag, "_tick"}, {31'd0, tick}, {31'd0, tp[i]});
      if (i < n - 1) step();
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step(); step();
    chk("rst_clk", {31'd0, clk_out}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_err", {31'd0, cfg_err}, 0);
    chk("rst_run", {31'd0, running}, 0);
    chk("rst_rdy", {31'd0, cfg_ready}, 1);
    chk("rst_div", {16'd0, cur_div}, 4);

    // basic divide-by-4
    rst = 1'b1; en = 1'b1;
    step();
    chk("a_run", {31'd0, running}, 1);
    run_pat("a", 8, 8'h33, 8'h88);

    // illegal ratio
    step();
    chk("c_rdy0", {31'd0, cfg_ready}, 1);
    cfg_valid = 1'b1; cfg_div = 16'd1;
    step(); cfg_valid = 1'b0;
    chk("c_err", {31'd0, cfg_err}, 1);
    chk("c_rdy", {31'd0, cfg_ready}, 1);
    chk("c_div", {16'd0, cur_div}, 4);
    chk("c_clk1", {31'd0, clk_out}, 1);
    step();
    chk("c_err_off", {31'd0, cfg_err}, 0);
    chk("c_clk2", {31'd0, clk_out}, 0);
    step();
    chk("c_tick", {31'd0, tick}, 1);

    // drain to stop, then drain and re-enable
    step();
    chk("d_clk0", {31'd0, clk_out}, 1);
    step(); en = 1'b0;
    step();
    chk("d_drain_run", {31'd0, running}, 1);
    chk("d_drain_clk", {31'd0, clk_out}, 0);
    step();
    chk("d_last_tick", {31'd0, tick}, 1);
    chk("d_last_run", {31'd0, running}, 1);
    step();
    chk("d_stop_run", {31'd0, running}, 0);
    chk("d_stop_clk", {31'd0, clk_out}, 0);
    chk("d_stop_tick", {31'd0, tick}, 0);
    step();
    chk("d_stop2_clk", {31'd0, clk_out}, 0);
    en = 1'b1;
    step();
    chk("d_start_clk", {31'd0, clk_out}, 1);
    step(); en = 1'b0;
    step();
    chk("d_dr2_run", {31'd0, running}, 1);
    chk("d_dr2_clk", {31'd0, clk_out}, 0);
    en = 1'b1;
    step();
    chk("d_dr2_tick", {31'd0, tick}, 1);
    step();
    chk("d_cont_clk", {31'd0, clk_out}, 1);
    chk("d_cont_run", {31'd0, running}, 1);
    step();
    chk("d_cont_clk1", {31'd0, clk_out}, 1);

    // ratio 4 -> 5 mid-period
    cfg_valid = 1'b1; cfg_div = 16'd5;
    step(); cfg_valid = 1'b0;
    chk("b_rdy2", {31'd0, cfg_ready}, 0);
    chk("b_div2", {16'd0, cur_div}, 4);
    chk("b_clk2", {31'd0, clk_out}, 0);
    step();
    chk("b_rdy3", {31'd0, cfg_ready}, 0);
    chk("b_tick3", {31'd0, tick}, 1);
    step();
    chk("b_div5", {16'd0, cur_div}, 5);
    chk("b_rdy", {31'd0, cfg_ready}, 1);
    run_pat("b", 5, 8'h03, 8'h10);

    // reset with clk_out high and a pending ratio
    step();
    chk("e_clk0", {31'd0, clk_out}, 1);
    cfg_valid = 1'b1; cfg_div = 16'd7;
    step(); cfg_valid = 1'b0;
    chk("e_rdy_pend", {31'd0, cfg_ready}, 0);
    chk("e_clk1", {31'd0, clk_out}, 1);
    rst = 1'b0;
    step();
    chk("e_clk", {31'd0, clk_out}, 0);
    chk("e_div", {16'd0, cur_div}, 4);
    chk("e_rdy", {31'd0, cfg_ready}, 1);
    chk("e_run", {31'd0, running}, 0);
    chk("e_tick", {31'd0, tick}, 0);
    rst = 1'b1;
    step();
    chk("e_restart_clk", {31'd0, clk_out}, 1);
    chk("e_restart_div", {16'd0, cur_div}, 4);

    // transfer on boundary edge 4 -> 6
    step(); step(); step();
    chk("f_tick", {31'd0, tick}, 1);
    cfg_valid = 1'b1; cfg_div = 16'd6;
    step(); cfg_valid = 1'b0;
    chk("f_div_still4", {16'd0, cur_div}, 4);
    chk("f_rdy0", {31'd0, cfg_ready}, 0);
    run_pat("f4", 4, 8'h03, 8'h08);
    step();
    chk("f_div6", {16'd0, cur_div}, 6);
    chk("f_rdy1", {31'd0, cfg_ready}, 1);
    run_pat("f6", 6, 8'h07, 8'h20);

    // en drop on boundary edge, then ratio applied while stopped
    en = 1'b0;
    step();
    chk("g_run", {31'd0, running}, 0);
    chk("g_clk", {31'd0, clk_out}, 0);
    cfg_valid = 1'b1; cfg_div = 16'd3;
    step(); cfg_valid = 1'b0;
    chk("g_rdy0", {31'd0, cfg_ready}, 0);
    chk("g_div6", {16'd0, cur_div}, 6);
    step();
    chk("g_rdy1", {31'd0, cfg_ready}, 1);
    chk("g_div3", {16'd0, cur_div}, 3);
    en = 1'b1;
    step();
    run_pat("g3", 6, 8'h09, 8'h24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
